uart_rx: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 12 +
 rtl/uart_rx_sync2.sv | 21 ++
 rtl/uart_rx.sv | 109 ++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Board-level constants and FSM encodings shared by the UART receive path.
package uart_rx_pkg;

    // 25 MHz clock, 115200 baud; the transmit block uses the same value
    localparam int CLKS_PER_BIT_DEFAULT = 217;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for asynchronous inputs; both flops reset to 1 (idle high).
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start/stop validation, ready/overrun
// handshake with the CPU side.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on rx_s
// ST_START | timing half a bit, then confirming the start bit is low
// ST_DATA  | sampling 8 data bits LSB first, one per bit period
// ST_STOP  | waiting one bit period, then validating the stop bit
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       clear,
    output logic [7:0] data,
    output logic       ready,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            ready     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (clear) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        if (idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        // Rearm half a bit early so gapless frames are caught
                        state <= ST_IDLE;
                        if (rx_s) begin
                            // A good stop overrides a same-cycle clear
                            data    <= shift;
                            ready   <= 1'b1;
                            overrun <= !clear && (overrun || ready);
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: behavioural transmitter plus a byte scoreboard.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overrun;
    logic       frame_err;

    int n_checks = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .clear     (clear),
        .data      (data),
        .ready     (ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: a byte is delivered when ready rises or data changes
    logic [7:0] data_prev = 8'h00;
    logic       ready_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (frame_err) fe_cnt++;
        if (!reset && ((ready && !ready_prev) || (data != data_prev))) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'h0, data}, 32'hFFFF_FFFF);
            end else begin
                chk("rx_byte", {24'h0, data}, {24'h0, exp_q.pop_front()});
            end
        end
        data_prev  = data;
        ready_prev = ready;
    end

    task automatic tx_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Starts on a negedge; ends right after the stop bit with no idle gap
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        if (stop_ok) exp_q.push_back(b);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(b[i]);
        tx_bit(stop_ok);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;

        idle(100);
        chk("reset_data", {24'h0, data}, 32'h00);
        chk("reset_ready", {31'h0, ready}, 32'h0);
        chk("reset_overrun", {31'h0, overrun}, 32'h0);
        chk("idle_no_frame_err", fe_cnt, 0);

        send_byte(8'h55, 1'b1);
        idle(10);
        chk("first_ready", {31'h0, ready}, 32'h1);
        chk("first_data", {24'h0, data}, 32'h55);
        pulse_clear();
        chk("cleared_ready", {31'h0, ready}, 32'h0);
        send_byte(8'hA3, 1'b1);
        idle(10);
        chk("second_ready", {31'h0, ready}, 32'h1);
        chk("second_data", {24'h0, data}, 32'hA3);
        pulse_clear();

        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(30);
        chk("glitch_ready", {31'h0, ready}, 32'h0);
        chk("glitch_data", {24'h0, data}, 32'hA3);
        send_byte(8'h3C, 1'b1);
        idle(10);
        chk("post_glitch_ready", {31'h0, ready}, 32'h1);
        chk("post_glitch_data", {24'h0, data}, 32'h3C);
        pulse_clear();

        fe_cnt = 0;
        send_byte(8'h81, 1'b0);
        idle(30);
        chk("frame_err_pulses", fe_cnt, 1);
        chk("frame_err_data", {24'h0, data}, 32'h3C);
        chk("frame_err_ready", {31'h0, ready}, 32'h0);

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(10);
        chk("b2b_data", {24'h0, data}, 32'h22);
        chk("b2b_ready", {31'h0, ready}, 32'h1);
        chk("b2b_overrun", {31'h0, overrun}, 32'h1);
        pulse_clear();
        chk("b2b_clr_ready", {31'h0, ready}, 32'h0);
        chk("b2b_clr_overrun", {31'h0, overrun}, 32'h0);

        // ready is already set when the next stop is accepted alongside clear
        send_byte(8'h66, 1'b1);
        idle(10);
        fork
            send_byte(8'h99, 1'b1);
            begin
                @(negedge clk);
                repeat (78) @(negedge clk);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end
        join
        idle(10);
        chk("set_wins_ready", {31'h0, ready}, 32'h1);
        chk("set_wins_overrun", {31'h0, overrun}, 32'h0);
        chk("set_wins_data", {24'h0, data}, 32'h99);

        @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("midreset_data", {24'h0, data}, 32'h00);
        chk("midreset_ready", {31'h0, ready}, 32'h0);
        chk("midreset_overrun", {31'h0, overrun}, 32'h0);
        chk("midreset_frame_err", {31'h0, frame_err}, 32'h0);
        idle(20);
        send_byte(8'h5A, 1'b1);
        idle(10);
        chk("after_reset_ready", {31'h0, ready}, 32'h1);
        chk("after_reset_data", {24'h0, data}, 32'h5A);

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
